gps_sat_scheduler: RTL

Time-multiplexing controller placed between the UART register bank and the GPS generator core. It holds a small table of satellite profiles (PRN, C/A phase, Doppler, SNR) and drives the core's configuration inputs from one profile at a time. Each valid profile runs for a programmable number of C/A code epochs, then the scheduler switches to the next valid profile. This lets one core emulate several satellites in round-robin order.

---
 rtl/gps_gen_pkg.sv | 46 ++++
 rtl/gps_sat_scheduler_if.sv | 51 +++++
 rtl/sched_profile_table.sv | 65 ++++++
 rtl/gps_sat_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gps_gen_pkg.sv
// -----------------------------------------------------------------------------
// gps_gen_pkg
// Purpose : Shared definitions for the GPS generator scheduling slice:
//           satellite profile field widths, the packed profile struct, the
//           scheduler state enum and a helper that sizes a table entry.
// Ports   : none (package).
// Config  : SCHED_SLOT_DWELL_EN - when defined, every table entry carries its
//           own dwell field above the profile bits.
// -----------------------------------------------------------------------------
package gps_gen_pkg;

  localparam int NSAT_W    = 5;
  localparam int CAPH_W    = 16;
  localparam int DOPP_W    = 8;
  localparam int SNR_W     = 8;
  localparam int PROFILE_W = 1 + NSAT_W + CAPH_W + DOPP_W + SNR_W;  // 38
  localparam int VALID_BIT = PROFILE_W - 1;

`ifdef SCHED_SLOT_DWELL_EN
  localparam bit SLOT_DWELL_EN = 1'b1;
`else
  localparam bit SLOT_DWELL_EN = 1'b0;
`endif

  typedef struct packed {
    logic              valid;
    logic [NSAT_W-1:0] n_sat;
    logic [CAPH_W-1:0] ca_phase;
    logic [DOPP_W-1:0] doppler;
    logic [SNR_W-1:0]  snr;
  } profile_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } sched_state_t;

  // Width of one table entry / write word: the profile, plus the per-slot
  // dwell field in the MSBs when that option is built in.
  function automatic int entry_w(input int dwell_w);
    return PROFILE_W + (SLOT_DWELL_EN ? dwell_w : 0);
  endfunction

endpackage

// File: rtl/gps_sat_scheduler_if.sv
// -----------------------------------------------------------------------------
// gps_sat_scheduler_if
// Purpose : Bundles the register-bank side (enable, table write, dwell), the
//           epoch pulse from the core and the core configuration outputs of
//           the satellite scheduler.
// Modports: master - register bank / core side (drives *_in, reads *_out)
//           slave  - the scheduler (reads *_in, drives *_out)
// Signals : enable_in, wr_en_in, wr_addr_in[clog2(N_SLOTS)], wr_data_in
//           [entry_w(DWELL_W)], dwell_in[DWELL_W], epoch_in, core_ena_out,
//           n_sat_out[5], ca_phase_out[16], doppler_out[8], snr_out[8],
//           slot_out[clog2(N_SLOTS)], switch_out.
// Config  : SCHED_SLOT_DWELL_EN widens wr_data_in by DWELL_W bits.
// -----------------------------------------------------------------------------
interface gps_sat_scheduler_if
  import gps_gen_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int DWELL_W = 8
);

  localparam int AW   = $clog2(N_SLOTS);
  localparam int WR_W = entry_w(DWELL_W);

  logic               enable_in;
  logic               wr_en_in;
  logic [AW-1:0]      wr_addr_in;
  logic [WR_W-1:0]    wr_data_in;
  logic [DWELL_W-1:0] dwell_in;
  logic               epoch_in;

  logic               core_ena_out;
  logic [NSAT_W-1:0]  n_sat_out;
  logic [CAPH_W-1:0]  ca_phase_out;
  logic [DOPP_W-1:0]  doppler_out;
  logic [SNR_W-1:0]   snr_out;
  logic [AW-1:0]      slot_out;
  logic               switch_out;

  modport master (
    output enable_in, wr_en_in, wr_addr_in, wr_data_in, dwell_in, epoch_in,
    input  core_ena_out, n_sat_out, ca_phase_out, doppler_out, snr_out,
           slot_out, switch_out
  );

  modport slave (
    input  enable_in, wr_en_in, wr_addr_in, wr_data_in, dwell_in, epoch_in,
    output core_ena_out, n_sat_out, ca_phase_out, doppler_out, snr_out,
           slot_out, switch_out
  );

endinterface

// File: rtl/sched_profile_table.sv
// -----------------------------------------------------------------------------
// sched_profile_table
// Purpose : N_SLOTS x ENTRY_W profile register file. One synchronous write
//           port, one combinational read port. Only the valid bits are reset,
//           so an empty table is guaranteed without resetting the payload.
// Ports   : clk_in, rst_in (async, active-high)
//           i_wr_en, i_wr_addr, i_wr_data - write port (lands on next edge)
//           i_rd_addr, o_rd_data          - read port (old data on a
//                                           same-cycle write)
// -----------------------------------------------------------------------------
module sched_profile_table #(
  parameter int N_SLOTS   = 4,
  parameter int ENTRY_W   = 38,
  parameter int VALID_BIT = 37
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       i_wr_en,
  input  logic [$clog2(N_SLOTS)-1:0] i_wr_addr,
  input  logic [ENTRY_W-1:0]         i_wr_data,
  input  logic [$clog2(N_SLOTS)-1:0] i_rd_addr,
  output logic [ENTRY_W-1:0]         o_rd_data
);

  localparam int AW = $clog2(N_SLOTS);

  logic [N_SLOTS-1:0] w_valid;
  logic [ENTRY_W-1:0] w_words [N_SLOTS];
  logic [ENTRY_W-1:0] w_rd;

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
    logic               w_hit;
    logic               r_v;
    logic [ENTRY_W-1:0] r_word;

    assign w_hit = i_wr_en && (i_wr_addr == AW'(gi));

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_v <= 1'b0;
      end else if (w_hit) begin
        r_v <= i_wr_data[VALID_BIT];
      end
    end

    always_ff @(posedge clk_in) begin
      if (w_hit) begin
        r_word <= i_wr_data;
      end
    end

    assign w_valid[gi] = r_v;
    assign w_words[gi] = r_word;
  end

  // The payload copy of the valid bit is stale after reset; the reset-cleared
  // flag is the authoritative one.
  always_comb begin
    w_rd            = w_words[i_rd_addr];
    w_rd[VALID_BIT] = w_valid[i_rd_addr];
  end

  assign o_rd_data = w_rd;

endmodule

// File: rtl/gps_sat_scheduler.sv
// -----------------------------------------------------------------------------
// gps_sat_scheduler
// Purpose : Time-multiplexes one GPS generator core over a small table of
//           satellite profiles. Each valid profile runs for a programmable
//           number of code epochs, then the next valid profile is loaded
//           (round robin). Loading a profile drops core enable for at least
//           one cycle so the core restarts on the new satellite.
// Ports   : clk_in  - system clock
//           rst_in  - asynchronous active-high reset
//           bus     - gps_sat_scheduler_if.slave (table write, enable, dwell,
//                     epoch pulse in; core configuration, slot, switch out)
// Config  : SCHED_SLOT_DWELL_EN - defined: dwell comes from each table entry
//           (MSBs of wr_data_in), dwell_in unused. Undefined: global dwell_in.
// -----------------------------------------------------------------------------
module gps_sat_scheduler
  import gps_gen_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int DWELL_W = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  gps_sat_scheduler_if.slave  bus
);

  localparam int            AW        = $clog2(N_SLOTS);
  localparam int            ENTRY_W   = entry_w(DWELL_W);
  localparam logic [AW-1:0] SCAN_LAST = AW'(N_SLOTS - 1);

  sched_state_t       r_state;
  sched_state_t       w_state_next;
  logic [AW-1:0]      r_ptr;
  logic [AW-1:0]      r_scan;
  logic [DWELL_W-1:0] r_epoch_cnt;
  logic [DWELL_W-1:0] w_dwell;
  logic [ENTRY_W-1:0] w_entry;
  profile_t           w_prof;
  logic               w_load;
  logic               w_ptr_inc;
  logic               w_epoch_dec;

  logic               r_core_ena;
  logic               r_switch;
  logic [NSAT_W-1:0]  r_n_sat;
  logic [CAPH_W-1:0]  r_ca_phase;
  logic [DOPP_W-1:0]  r_doppler;
  logic [SNR_W-1:0]   r_snr;
  logic [AW-1:0]      r_slot;

  sched_profile_table #(
    .N_SLOTS   (N_SLOTS),
    .ENTRY_W   (ENTRY_W),
    .VALID_BIT (VALID_BIT)
  ) u_table (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_wr_en   (bus.wr_en_in),
    .i_wr_addr (bus.wr_addr_in),
    .i_wr_data (bus.wr_data_in),
    .i_rd_addr (r_ptr),
    .o_rd_data (w_entry)
  );

  assign w_prof = profile_t'(w_entry[PROFILE_W-1:0]);

`ifdef SCHED_SLOT_DWELL_EN
  assign w_dwell = w_entry[ENTRY_W-1 -: DWELL_W];
`else
  assign w_dwell = bus.dwell_in;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ptr_inc    = 1'b0;
    w_epoch_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable_in) w_state_next = SEARCH;
      end
      SEARCH: begin
        if (!bus.enable_in) begin
          w_state_next = IDLE;
        end else if (w_prof.valid) begin
          w_state_next = LOAD;
          w_load       = 1'b1;
        end else begin
          w_ptr_inc = 1'b1;
          if (r_scan == SCAN_LAST) w_state_next = IDLE;
        end
      end
      LOAD: begin
        w_state_next = RUN;
      end
      RUN: begin
        // The slot is finished on its terminal epoch even if enable drops in
        // the same cycle, so a later re-enable resumes at the following slot.
        if (bus.epoch_in) begin
          if (r_epoch_cnt == DWELL_W'(1)) begin
            w_ptr_inc    = 1'b1;
            w_state_next = SEARCH;
          end else begin
            w_epoch_dec = 1'b1;
          end
        end
        if (!bus.enable_in) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that switch_out is high
  // during LOAD and core_ena_out is high exactly while in RUN. The profile
  // is captured on the edge that enters LOAD.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ptr       <= '0;
      r_scan      <= '0;
      r_epoch_cnt <= '0;
      r_core_ena  <= 1'b0;
      r_switch    <= 1'b0;
      r_n_sat     <= '0;
      r_ca_phase  <= '0;
      r_doppler   <= '0;
      r_snr       <= '0;
      r_slot      <= '0;
    end else begin
      if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;

      if (r_state != SEARCH) begin
        r_scan <= '0;
      end else if (w_ptr_inc) begin
        r_scan <= r_scan + 1'b1;
      end

      if (w_load) begin
        r_n_sat     <= w_prof.n_sat;
        r_ca_phase  <= w_prof.ca_phase;
        r_doppler   <= w_prof.doppler;
        r_snr       <= w_prof.snr;
        r_slot      <= r_ptr;
        r_epoch_cnt <= (w_dwell == '0) ? DWELL_W'(1) : w_dwell;
      end else if (w_epoch_dec) begin
        r_epoch_cnt <= r_epoch_cnt - 1'b1;
      end

      r_core_ena <= (w_state_next == RUN);
      r_switch   <= (w_state_next == LOAD);
    end
  end

  assign bus.core_ena_out = r_core_ena;
  assign bus.switch_out   = r_switch;
  assign bus.n_sat_out    = r_n_sat;
  assign bus.ca_phase_out = r_ca_phase;
  assign bus.doppler_out  = r_doppler;
  assign bus.snr_out      = r_snr;
  assign bus.slot_out     = r_slot;

endmodule
